// File: rtl/rtc_read_sequencer.sv
// rtc_read_sequencer
//   Periodically sweeps nine RTC registers (date, time, countdown timer) over the
//   chip's multiplexed address/data bus. The values are held in shadow registers
//   and published to the VGA controller as one coherent snapshot. ALARMA is raised
//   when the countdown timer reaches 00:00:00.
//
// Optional feature (macro RTC_BCD_CHECK_EN): each snapshot is BCD/range checked
//   before it is published. A bad snapshot is discarded and BCD_ERR pulses instead.
//
// Ports:
//   CLK, RST            clock, asynchronous active-low reset
//   AD_IN               bus read data
//   AD_OUT, AD_OE       driven address and its tristate enable
//   CS_N, RD_N, WR_N    chip select, read strobe, write/address strobe (active-low)
//   A_D                 0 = address cycle, 1 = data cycle
//   *_T                 BCD snapshot outputs (time/date and timer)
//   DATA_VALID          one-cycle pulse while a new snapshot is published
//   ALARMA, ALARM_ACK   sticky timer-expired flag and its clear
//   BCD_ERR             (RTC_BCD_CHECK_EN only) one-cycle pulse on a rejected snapshot
module rtc_read_sequencer #(
    parameter int unsigned PH_CYC      = 5,
    parameter int unsigned REFRESH_CYC = 1000000
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic [7:0] AD_IN,
    output logic [7:0] AD_OUT,
    output logic       AD_OE,
    output logic       CS_N,
    output logic       RD_N,
    output logic       WR_N,
    output logic       A_D,
    output logic [7:0] SEGUNDO_T,
    output logic [7:0] MINUTO_T,
    output logic [7:0] HORA_T,
    output logic [7:0] DIA_T,
    output logic [7:0] MES_T,
    output logic [7:0] ANO_T,
    output logic [7:0] SEGUNDOT_T,
    output logic [7:0] MINUTOT_T,
    output logic [7:0] HORAT_T,
    output logic       DATA_VALID,
    output logic       ALARMA,
    input  logic       ALARM_ACK
`ifdef RTC_BCD_CHECK_EN
    ,
    output logic       BCD_ERR
`endif
);

    localparam int unsigned RW = (REFRESH_CYC > 1) ? $clog2(REFRESH_CYC) : 1;
    localparam int unsigned PW = (PH_CYC > 1) ? $clog2(PH_CYC) : 1;
    localparam logic [RW-1:0] RefLast = RW'(REFRESH_CYC - 1);
    localparam logic [PW-1:0] PhLast  = PW'(PH_CYC - 1);

    typedef enum logic [2:0] {StIdle, StAddr, StAhold, StData, StGap, StPublish} state_e;

    state_e        state_q, state_d;
    logic [PW-1:0] ph_q, ph_d;
    logic [3:0]    idx_q, idx_d;
    logic [RW-1:0] ref_q;
    logic [7:0]    shadow_q [9];
    logic [7:0]    snap_q   [9];
    logic          dv_q, alarm_q, bcd_err_q;

    logic tick, ph_last, last_reg, publish, snap_ok, timer_zero, prev_nonzero, alarm_set;

    function automatic logic [7:0] reg_addr(input logic [3:0] i);
        case (i)
            4'd0:    return 8'h21;
            4'd1:    return 8'h22;
            4'd2:    return 8'h23;
            4'd3:    return 8'h24;
            4'd4:    return 8'h25;
            4'd5:    return 8'h26;
            4'd6:    return 8'h41;
            4'd7:    return 8'h42;
            4'd8:    return 8'h43;
            default: return 8'h00;
        endcase
    endfunction

    assign tick     = (ref_q == '0);
    assign ph_last  = (ph_q == PhLast);
    assign last_reg = (idx_q == 4'd8);
    // Snapshot decisions are taken on the edge that enters StPublish, so the
    // new outputs and DATA_VALID appear together in the StPublish cycle.
    assign publish  = (state_q == StGap) && ph_last && last_reg;

`ifdef RTC_BCD_CHECK_EN
    function automatic logic digits_ok(input logic [7:0] b);
        return (b[7:4] <= 4'd9) && (b[3:0] <= 4'd9);
    endfunction

    always_comb begin
        snap_ok = 1'b1;
        for (int i = 0; i < 9; i++) begin
            snap_ok = snap_ok & digits_ok(shadow_q[i]);
        end
        snap_ok = snap_ok & (shadow_q[0] <= 8'h59) & (shadow_q[1] <= 8'h59)
                          & (shadow_q[2] <= 8'h23)
                          & (shadow_q[3] >= 8'h01) & (shadow_q[3] <= 8'h31)
                          & (shadow_q[4] >= 8'h01) & (shadow_q[4] <= 8'h12);
    end

    assign BCD_ERR = bcd_err_q;
`else
    assign snap_ok = 1'b1;
`endif

    assign timer_zero   = (shadow_q[6] == 8'h00) && (shadow_q[7] == 8'h00)
                       && (shadow_q[8] == 8'h00);
    assign prev_nonzero = (snap_q[6] != 8'h00) || (snap_q[7] != 8'h00) || (snap_q[8] != 8'h00);
    assign alarm_set    = publish && snap_ok && timer_zero && prev_nonzero;

    always_comb begin
        state_d = state_q;
        ph_d    = ph_q;
        idx_d   = idx_q;
        case (state_q)
            StIdle, StPublish: begin
                // A tick seen while busy (any other state) is simply lost.
                if (tick) begin
                    state_d = StAddr;
                    ph_d    = '0;
                    idx_d   = 4'd0;
                end else begin
                    state_d = StIdle;
                end
            end
            StAddr, StAhold, StData, StGap: begin
                if (!ph_last) begin
                    ph_d = ph_q + 1'b1;
                end else begin
                    ph_d = '0;
                    if (state_q == StAddr) begin
                        state_d = StAhold;
                    end else if (state_q == StAhold) begin
                        state_d = StData;
                    end else if (state_q == StData) begin
                        state_d = StGap;
                    end else if (last_reg) begin
                        state_d = StPublish;
                    end else begin
                        state_d = StAddr;
                        idx_d   = idx_q + 4'd1;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Bus signals decode straight from state so an async reset idles the bus at once.
    always_comb begin
        AD_OUT = 8'h00;
        AD_OE  = 1'b0;
        CS_N   = 1'b1;
        RD_N   = 1'b1;
        WR_N   = 1'b1;
        A_D    = 1'b0;
        case (state_q)
            StAddr: begin
                CS_N   = 1'b0;
                WR_N   = 1'b0;
                AD_OE  = 1'b1;
                AD_OUT = reg_addr(idx_q);
            end
            StAhold: begin
                CS_N   = 1'b0;
                AD_OE  = 1'b1;
                AD_OUT = reg_addr(idx_q);
            end
            StData: begin
                CS_N = 1'b0;
                RD_N = 1'b0;
                A_D  = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q   <= StIdle;
            ph_q      <= '0;
            idx_q     <= 4'd0;
            ref_q     <= '0;
            dv_q      <= 1'b0;
            alarm_q   <= 1'b0;
            bcd_err_q <= 1'b0;
            for (int i = 0; i < 9; i++) begin
                shadow_q[i] <= 8'h00;
                snap_q[i]   <= 8'h00;
            end
        end else begin
            state_q   <= state_d;
            ph_q      <= ph_d;
            idx_q     <= idx_d;
            ref_q     <= (ref_q == RefLast) ? '0 : ref_q + 1'b1;
            dv_q      <= publish && snap_ok;
            bcd_err_q <= publish && !snap_ok;
            alarm_q   <= alarm_set | (alarm_q & ~ALARM_ACK);
            if (state_q == StData && ph_last) begin
                shadow_q[idx_q] <= AD_IN;
            end
            if (publish && snap_ok) begin
                for (int i = 0; i < 9; i++) begin
                    snap_q[i] <= shadow_q[i];
                end
            end
        end
    end

    assign DATA_VALID = dv_q;
    assign ALARMA     = alarm_q;
    assign SEGUNDO_T  = snap_q[0];
    assign MINUTO_T   = snap_q[1];
    assign HORA_T     = snap_q[2];
    assign DIA_T      = snap_q[3];
    assign MES_T      = snap_q[4];
    assign ANO_T      = snap_q[5];
    assign SEGUNDOT_T = snap_q[6];
    assign MINUTOT_T  = snap_q[7];
    assign HORAT_T    = snap_q[8];

endmodule

// File: tb/tb_rtc_read_sequencer.sv
// Directed testbench for rtc_read_sequencer with PH_CYC=2, REFRESH_CYC=200.
// A small RTC model latches the address on the address strobe and returns a
// byte from its register map. A bus monitor counts protocol violations and logs
// the address of every register access.
module tb_rtc_read_sequencer;

    localparam int unsigned PH  = 2;
    localparam int unsigned REF = 200;

    logic       CLK = 1'b0;
    logic       RST = 1'b0;
    logic [7:0] AD_IN, AD_OUT;
    logic       AD_OE, CS_N, RD_N, WR_N, A_D;
    logic [7:0] SEGUNDO_T, MINUTO_T, HORA_T, DIA_T, MES_T, ANO_T;
    logic [7:0] SEGUNDOT_T, MINUTOT_T, HORAT_T;
    logic       DATA_VALID, ALARMA;
    logic       ALARM_ACK = 1'b0;
`ifdef RTC_BCD_CHECK_EN
    logic       BCD_ERR;
`endif

    always #5 CLK = ~CLK;

    rtc_read_sequencer #(
        .PH_CYC      (PH),
        .REFRESH_CYC (REF)
    ) dut (
        .CLK        (CLK),
        .RST        (RST),
        .AD_IN      (AD_IN),
        .AD_OUT     (AD_OUT),
        .AD_OE      (AD_OE),
        .CS_N       (CS_N),
        .RD_N       (RD_N),
        .WR_N       (WR_N),
        .A_D        (A_D),
        .SEGUNDO_T  (SEGUNDO_T),
        .MINUTO_T   (MINUTO_T),
        .HORA_T     (HORA_T),
        .DIA_T      (DIA_T),
        .MES_T      (MES_T),
        .ANO_T      (ANO_T),
        .SEGUNDOT_T (SEGUNDOT_T),
        .MINUTOT_T  (MINUTOT_T),
        .HORAT_T    (HORAT_T),
        .DATA_VALID (DATA_VALID),
        .ALARMA     (ALARMA),
        .ALARM_ACK  (ALARM_ACK)
`ifdef RTC_BCD_CHECK_EN
        ,
        .BCD_ERR    (BCD_ERR)
`endif
    );

    // RTC model
    logic [7:0] mem [256];
    logic [7:0] lat_addr = 8'h00;
    always @(posedge CLK) begin
        if (!CS_N && !WR_N && AD_OE) lat_addr <= AD_OUT;
    end
    assign AD_IN = mem[lat_addr];

    // Cycle counter: cycle 1 is the first rising edge after reset release.
    int cyc;
    always @(posedge CLK or negedge RST) begin
        if (!RST) cyc <= 0;
        else      cyc <= cyc + 1;
    end

    // Bus monitor
    int         viol = 0;
    int         addr_n = 0;
    logic [7:0] addr_log [256];
    logic       wr_prev = 1'b1;
    always @(negedge CLK) begin
        if (AD_OE && !RD_N) viol <= viol + 1;
        if (CS_N && (!RD_N || !WR_N)) viol <= viol + 1;
        wr_prev <= WR_N;
        if (wr_prev && !WR_N && addr_n < 256) begin
            addr_log[addr_n] <= AD_OUT;
            addr_n           <= addr_n + 1;
        end
    end

    int n_checks = 0;
    int n_err    = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic wait_dv(input string tag, output int c);
        int n = 0;
        do begin
            @(negedge CLK);
            n++;
        end while (!DATA_VALID && n < 400);
        check(tag, {31'd0, DATA_VALID}, 1);
        c = cyc;
    endtask

    task automatic wait_cyc(input int target);
        while (cyc < target) @(negedge CLK);
    endtask

    logic [7:0] exp_addr [9] = '{8'h21, 8'h22, 8'h23, 8'h24, 8'h25, 8'h26, 8'h41, 8'h42, 8'h43};

    initial begin
        int c1, c2, c3, cp, mark, n;
        for (int i = 0; i < 256; i++) mem[i] = 8'h00;
        mem[8'h21] = 8'h45; mem[8'h22] = 8'h30; mem[8'h23] = 8'h13;
        mem[8'h24] = 8'h10; mem[8'h25] = 8'h04; mem[8'h26] = 8'h24;
        mem[8'h41] = 8'h01; mem[8'h42] = 8'h00; mem[8'h43] = 8'h00;

        repeat (3) @(posedge CLK);
        @(negedge CLK);
        check("rst_bus", {27'd0, AD_OE, CS_N, RD_N, WR_N, A_D}, 32'b01110);
        check("rst_ad_out", {24'd0, AD_OUT}, 0);
        check("rst_flags", {30'd0, DATA_VALID, ALARMA}, 0);
        check("rst_snap", {24'd0, SEGUNDO_T | MINUTO_T | HORA_T | DIA_T | MES_T | ANO_T
                           | SEGUNDOT_T | MINUTOT_T | HORAT_T}, 0);
        RST = 1'b1;

        // First sweep
        wait_dv("dv1", c1);
        check("dv1_cycle", c1, 73);
        check("dv1_seg", {24'd0, SEGUNDO_T}, 32'h45);
        check("dv1_min", {24'd0, MINUTO_T}, 32'h30);
        check("dv1_hora", {24'd0, HORA_T}, 32'h13);
        check("dv1_dia", {24'd0, DIA_T}, 32'h10);
        check("dv1_mes", {24'd0, MES_T}, 32'h04);
        check("dv1_ano", {24'd0, ANO_T}, 32'h24);
        check("dv1_segt", {24'd0, SEGUNDOT_T}, 32'h01);
        check("dv1_alarm", {31'd0, ALARMA}, 0);
        for (int i = 0; i < 9; i++) check($sformatf("addr_%0d", i), {24'd0, addr_log[i]},
                                          {24'd0, exp_addr[i]});
        @(negedge CLK);
        check("dv1_pulse_end", {31'd0, DATA_VALID}, 0);

        // Coherency: change data before sweep 2 reads it, outputs must hold
        wait_cyc(202);
        mem[8'h21] = 8'h46;
        mem[8'h41] = 8'h00;
        wait_cyc(250);
        check("coh_seg_hold", {24'd0, SEGUNDO_T}, 32'h45);
        check("coh_alarm_pre", {31'd0, ALARMA}, 0);
        wait_dv("dv2", c2);
        check("dv2_period", c2 - c1, REF);
        check("dv2_seg", {24'd0, SEGUNDO_T}, 32'h46);
        check("dv2_segt", {24'd0, SEGUNDOT_T}, 32'h00);
        check("alarm_set", {31'd0, ALARMA}, 1);

        // Alarm stays set on a further zero sweep, ack clears it, no re-set
        wait_dv("dv3", c3);
        check("alarm_sticky", {31'd0, ALARMA}, 1);
        @(negedge CLK);
        ALARM_ACK = 1'b1;
        @(negedge CLK);
        ALARM_ACK = 1'b0;
        check("alarm_ack", {31'd0, ALARMA}, 0);
        wait_dv("dv4", cp);
        check("alarm_no_reset", {31'd0, ALARMA}, 0);

        // Steady-state sweeps 5..10
        for (int i = 5; i <= 10; i++) begin
            int c;
            wait_dv($sformatf("dv%0d", i), c);
            check($sformatf("period_%0d", i), c - cp, REF);
            cp = c;
        end
        check("bus_violations", viol, 0);

        // Reset during DATA of register 5 (0x25)
        n = 0;
        do begin
            @(negedge CLK);
            n++;
        end while (!(A_D && addr_log[addr_n - 1] == 8'h25) && n < 400);
        check("reached_reg5_data", {31'd0, A_D}, 1);
        #1 RST = 1'b0;
        #1;
        check("mid_rst_bus", {29'd0, CS_N, AD_OE, RD_N}, 32'b101);
        check("mid_rst_snap", {24'd0, SEGUNDO_T | MES_T | SEGUNDOT_T}, 0);
        @(negedge CLK);
        mark = addr_n;
        RST  = 1'b1;
        wait_dv("dv_after_rst", c1);
        check("rst_dv_cycle", c1, 73);
        check("rst_first_addr", {24'd0, addr_log[mark]}, 32'h21);
        check("rst_seg", {24'd0, SEGUNDO_T}, 32'h46);

`ifdef RTC_BCD_CHECK_EN
        mem[8'h22] = 8'h1A;
        n = 0;
        do begin
            @(negedge CLK);
            n++;
        end while (!BCD_ERR && n < 250);
        check("bcd_err", {31'd0, BCD_ERR}, 1);
        check("bcd_no_dv", {31'd0, DATA_VALID}, 0);
        check("bcd_min_hold", {24'd0, MINUTO_T}, 32'h30);
        @(negedge CLK);
        check("bcd_err_pulse", {31'd0, BCD_ERR}, 0);
`endif

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
